// File: rtl/id_ex_if.sv
// ID/EX pipeline register bus: ID-stage payload and controls in, EX-stage payload and counters out.
//   flush, freeze, valid_in, *_in      : driven by the ID stage / hazard unit (master)
//   valid_out, *_out, flush_cnt, stall_cnt : driven by the pipeline register (slave)
interface id_ex_if #(
  parameter int unsigned DATA_W = 32
);
  logic              flush;
  logic              freeze;
  logic              valid_in;
  logic [9:0]        ctrl_in;
  logic [DATA_W-1:0] PC_in;
  logic [DATA_W-1:0] val_Rn_in;
  logic [DATA_W-1:0] val_Rm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [3:0]        dest_in;
  logic [3:0]        src1_in;
  logic [3:0]        src2_in;
  logic [3:0]        SR_in;

  logic              valid_out;
  logic [9:0]        ctrl_out;
  logic [DATA_W-1:0] PC_out;
  logic [DATA_W-1:0] val_Rn_out;
  logic [DATA_W-1:0] val_Rm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm_24_out;
  logic [3:0]        dest_out;
  logic [3:0]        src1_out;
  logic [3:0]        src2_out;
  logic [3:0]        SR_out;
  logic [15:0]       flush_cnt;
  logic [15:0]       stall_cnt;

  modport master (
    output flush, freeze, valid_in, ctrl_in, PC_in, val_Rn_in, val_Rm_in,
           shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in, SR_in,
    input  valid_out, ctrl_out, PC_out, val_Rn_out, val_Rm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, SR_out, flush_cnt, stall_cnt
  );

  modport slave (
    input  flush, freeze, valid_in, ctrl_in, PC_in, val_Rn_in, val_Rm_in,
           shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in, SR_in,
    output valid_out, ctrl_out, PC_out, val_Rn_out, val_Rm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, SR_out, flush_cnt, stall_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush (bubble), freeze (stall) and saturating event counters.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every output and both counters
//   bus : id_ex_if slave port carrying the ID payload in and the EX payload out
module id_ex_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);
  localparam int unsigned CTRL_W  = 10;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_val_rn;
  logic [DATA_W-1:0] r_val_rm;
  logic [11:0]       r_shift_operand;
  logic [23:0]       r_signed_imm_24;
  logic [3:0]        r_dest;
  logic [3:0]        r_src1;
  logic [3:0]        r_src2;
  logic [3:0]        r_sr;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [CTRL_W-1:0] w_ctrl_load;

  // An invalid slot must not write back, touch memory or branch; keep imm/EXE_CMD as-is.
  assign w_ctrl_load = bus.valid_in ? bus.ctrl_in : {5'b0, bus.ctrl_in[4:0]};

  // Stage register: rst > flush > freeze > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid         <= 1'b0;
      r_ctrl          <= '0;
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_sr            <= '0;
      r_flush_cnt     <= '0;
      r_stall_cnt     <= '0;
    end else if (bus.flush) begin
      r_valid         <= 1'b0;
      r_ctrl          <= '0;
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_sr            <= '0;
      r_flush_cnt     <= (r_flush_cnt == CNT_MAX) ? r_flush_cnt : r_flush_cnt + CNT_W'(1);
    end else if (bus.freeze) begin
      r_stall_cnt     <= (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
    end else begin
      r_valid         <= bus.valid_in;
      r_ctrl          <= w_ctrl_load;
      r_pc            <= bus.PC_in;
      r_val_rn        <= bus.val_Rn_in;
      r_val_rm        <= bus.val_Rm_in;
      r_shift_operand <= bus.shift_operand_in;
      r_signed_imm_24 <= bus.signed_imm_24_in;
      r_dest          <= bus.dest_in;
      r_src1          <= bus.src1_in;
      r_src2          <= bus.src2_in;
      r_sr            <= bus.SR_in;
    end
  end

  assign bus.valid_out         = r_valid;
  assign bus.ctrl_out          = r_ctrl;
  assign bus.PC_out            = r_pc;
  assign bus.val_Rn_out        = r_val_rn;
  assign bus.val_Rm_out        = r_val_rm;
  assign bus.shift_operand_out = r_shift_operand;
  assign bus.signed_imm_24_out = r_signed_imm_24;
  assign bus.dest_out          = r_dest;
  assign bus.src1_out          = r_src1;
  assign bus.src2_out          = r_src2;
  assign bus.SR_out            = r_sr;
  assign bus.flush_cnt         = r_flush_cnt;
  assign bus.stall_cnt         = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios with literal expectations,
// a randomized run checked every cycle against a behavioural model, and counter saturation.
module tb_id_ex_reg;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst;
  id_ex_if #(.DATA_W(DATA_W)) bus ();

  id_ex_reg #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the EX stage must hold, derived from the stage rules.
  logic        m_valid = 1'b0;
  logic [9:0]  m_ctrl  = '0;
  logic [31:0] m_pc = '0, m_rn = '0, m_rm = '0;
  logic [11:0] m_shift = '0;
  logic [23:0] m_imm = '0;
  logic [3:0]  m_dest = '0, m_s1 = '0, m_s2 = '0, m_sr = '0;
  int          m_flushes = 0;
  int          m_stalls  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_pc <= '0; m_rn <= '0; m_rm <= '0;
      m_shift <= '0; m_imm <= '0; m_dest <= '0; m_s1 <= '0; m_s2 <= '0; m_sr <= '0;
      m_flushes <= 0; m_stalls <= 0;
    end else if (bus.flush) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_pc <= '0; m_rn <= '0; m_rm <= '0;
      m_shift <= '0; m_imm <= '0; m_dest <= '0; m_s1 <= '0; m_s2 <= '0; m_sr <= '0;
      m_flushes <= (m_flushes < 65535) ? m_flushes + 1 : 65535;
    end else if (bus.freeze) begin
      m_stalls <= (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else begin
      m_valid <= bus.valid_in;
      m_ctrl  <= bus.valid_in ? bus.ctrl_in : (bus.ctrl_in & 10'h01F);
      m_pc <= bus.PC_in; m_rn <= bus.val_Rn_in; m_rm <= bus.val_Rm_in;
      m_shift <= bus.shift_operand_in; m_imm <= bus.signed_imm_24_in;
      m_dest <= bus.dest_in; m_s1 <= bus.src1_in; m_s2 <= bus.src2_in; m_sr <= bus.SR_in;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("valid_out", 64'(bus.valid_out), 64'(m_valid));
    chk("ctrl_out", 64'(bus.ctrl_out), 64'(m_ctrl));
    chk("PC_out", 64'(bus.PC_out), 64'(m_pc));
    chk("val_Rn_out", 64'(bus.val_Rn_out), 64'(m_rn));
    chk("val_Rm_out", 64'(bus.val_Rm_out), 64'(m_rm));
    chk("shift_operand_out", 64'(bus.shift_operand_out), 64'(m_shift));
    chk("signed_imm_24_out", 64'(bus.signed_imm_24_out), 64'(m_imm));
    chk("dest_out", 64'(bus.dest_out), 64'(m_dest));
    chk("src1_out", 64'(bus.src1_out), 64'(m_s1));
    chk("src2_out", 64'(bus.src2_out), 64'(m_s2));
    chk("SR_out", 64'(bus.SR_out), 64'(m_sr));
    chk("flush_cnt", 64'(bus.flush_cnt), 64'(m_flushes));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stalls));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_zero();
    bus.flush = 1'b0; bus.freeze = 1'b0; bus.valid_in = 1'b0; bus.ctrl_in = '0;
    bus.PC_in = '0; bus.val_Rn_in = '0; bus.val_Rm_in = '0; bus.shift_operand_in = '0;
    bus.signed_imm_24_in = '0; bus.dest_in = '0; bus.src1_in = '0; bus.src2_in = '0;
    bus.SR_in = '0;
  endtask

  task automatic drive_rand_payload();
    bus.valid_in = 1'($urandom);
    bus.ctrl_in = 10'($urandom);
    bus.PC_in = $urandom; bus.val_Rn_in = $urandom; bus.val_Rm_in = $urandom;
    bus.shift_operand_in = 12'($urandom); bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in = 4'($urandom); bus.src1_in = 4'($urandom);
    bus.src2_in = 4'($urandom); bus.SR_in = 4'($urandom);
  endtask

  initial begin
    drive_zero();
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset valid_out", 64'(bus.valid_out), 64'h0);
    rst = 1'b0;

    // Plain load, visible after one edge.
    bus.valid_in = 1'b1; bus.ctrl_in = 10'h205; bus.val_Rn_in = 32'h5;
    bus.PC_in = 32'h8; bus.dest_in = 4'h3;
    step();
    chk("load ctrl_out", 64'(bus.ctrl_out), 64'h205);
    chk("load val_Rn_out", 64'(bus.val_Rn_out), 64'h5);
    chk("load PC_out", 64'(bus.PC_out), 64'h8);
    chk("load dest_out", 64'(bus.dest_out), 64'h3);
    chk("load valid_out", 64'(bus.valid_out), 64'h1);

    // Freeze for three edges while inputs change.
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand_payload();
      step();
    end
    chk("freeze ctrl_out", 64'(bus.ctrl_out), 64'h205);
    chk("freeze PC_out", 64'(bus.PC_out), 64'h8);
    chk("freeze valid_out", 64'(bus.valid_out), 64'h1);
    chk("freeze stall_cnt", 64'(bus.stall_cnt), 64'd3);

    // Flush together with freeze: bubble, only flush counted.
    bus.flush = 1'b1;
    step();
    chk("flush valid_out", 64'(bus.valid_out), 64'h0);
    chk("flush ctrl_out", 64'(bus.ctrl_out), 64'h0);
    chk("flush flush_cnt", 64'(bus.flush_cnt), 64'd1);
    chk("flush stall_cnt", 64'(bus.stall_cnt), 64'd3);

    // Invalid slot: side-effect control bits dropped, data still loads.
    bus.flush = 1'b0; bus.freeze = 1'b0;
    bus.valid_in = 1'b0; bus.ctrl_in = 10'h3FF; bus.val_Rm_in = 32'hAB;
    step();
    chk("invalid ctrl_out", 64'(bus.ctrl_out), 64'h01F);
    chk("invalid val_Rm_out", 64'(bus.val_Rm_out), 64'hAB);
    chk("invalid valid_out", 64'(bus.valid_out), 64'h0);

    // Asynchronous reset between edges.
    bus.valid_in = 1'b1; bus.ctrl_in = 10'h3FF;
    step();
    chk("pre-reset ctrl_out", 64'(bus.ctrl_out), 64'h3FF);
    #2 rst = 1'b1;
    #1;
    chk("async rst ctrl_out", 64'(bus.ctrl_out), 64'h0);
    chk("async rst valid_out", 64'(bus.valid_out), 64'h0);
    chk("async rst flush_cnt", 64'(bus.flush_cnt), 64'h0);
    chk("async rst stall_cnt", 64'(bus.stall_cnt), 64'h0);

    // Edges during reset do nothing, even with flush and freeze.
    bus.flush = 1'b1; bus.freeze = 1'b1;
    step();
    step();
    chk("rst hold flush_cnt", 64'(bus.flush_cnt), 64'h0);
    chk("rst hold stall_cnt", 64'(bus.stall_cnt), 64'h0);

    // After release the stage stays a bubble until the first load edge.
    rst = 1'b0; bus.flush = 1'b0;
    step();
    chk("post-rst bubble valid_out", 64'(bus.valid_out), 64'h0);
    chk("post-rst stall_cnt", 64'(bus.stall_cnt), 64'h1);
    bus.freeze = 1'b0;
    step();
    chk("post-rst load valid_out", 64'(bus.valid_out), 64'h1);
    chk("post-rst load ctrl_out", 64'(bus.ctrl_out), 64'h3FF);

    // Randomized run with occasional mid-cycle reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive_rand_payload();
      bus.flush  = ($urandom_range(0, 9) == 0);
      bus.freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      step();
    end

    // Flush counter saturation without wrap.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    drive_zero();
    bus.flush = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.freeze = 1'($urandom);
      step();
    end
    chk("sat flush_cnt", 64'(bus.flush_cnt), 64'hFFFF);
    chk("sat stall_cnt", 64'(bus.stall_cnt), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
